red_pitaya_product_sat_mc: RTL and testbench
============================================

# red_pitaya_product_sat_mc

Multi-channel, pipelined, saturating fixed-point multiplier with a runtime-selectable output shift and rounding mode. It tracks data validity through the pipeline and gives per-channel overflow status (per-sample, sticky, counted). It sits between DSP stages (PID, IQ demodulator, scaler) that need a scaled product with guaranteed no-wrap output. It serves several channels from one instance and one register set.

## Interface
- CHANNELS, 2, number of independent lanes
- BITS_IN1, 14, signed width of factor1 per lane
- BITS_IN2, 16, signed width of factor2 per lane
- BITS_OUT, 14, signed width of product per lane
- SHIFT_MAX, 31, largest honoured right shift; SHIFT_W = clog2(SHIFT_MAX+1)
- CNT_BITS, 16, overflow counter width per lane
- clk  in  1  single system clock, all logic on rising edge
- rstn_i  in  1  asynchronous, active-low reset
- valid_i  in  1  input sample strobe, common to all lanes
- factor1_i  in  CHANNELS*BITS_IN1  packed lane operands, lane 0 in LSBs
- factor2_i  in  CHANNELS*BITS_IN2  packed lane operands
- shift_i  in  SHIFT_W  arithmetic right shift applied to the full product
- round_i  in  1  1 = round half up, 0 = truncate toward minus infinity
- clear_i  in  1  synchronous clear of sticky flags and counters
- valid_o  out  1  output strobe
- product_o  out  CHANNELS*BITS_OUT  saturated, shifted products
- overflow_o  out  CHANNELS  per-sample saturation flag, qualified by valid_o
- sticky_o  out  CHANNELS  set on any saturation since the last clear or reset
- ovf_cnt_o  out  CHANNELS*CNT_BITS  saturating count of saturated samples

## Operation
- Full product width is P = BITS_IN1+BITS_IN2+1. The extra bit absorbs the rounding add, so the intermediate value can never wrap.
- shift_i and round_i are captured together with valid_i and travel with the sample. Changing them mid-stream affects only later samples.
- If shift_i > SHIFT_MAX, the shift is clamped to SHIFT_MAX.
- Stage 1: p = f1*f2. When round_i=1 and shift>0, add 2^(shift-1). Otherwise add nothing.
- Stage 2: s = p >>> shift (arithmetic shift).
- Stage 3 (saturate):
  - s > 2^(BITS_OUT-1)-1 → output the max value, overflow=1.
  - s < -2^(BITS_OUT-1) → output the min value, overflow=1.
  - otherwise → output s[BITS_OUT-1:0], overflow=0.
- product_o updates only on cycles where valid_o=1. It holds its value otherwise.
- overflow_o is 0 whenever valid_o=0.
- sticky_o[k] sets on any valid saturated sample in lane k.
- ovf_cnt_o[k] increments on each valid saturated sample and saturates at all-ones (never wraps).
- clear_i together with an overflow in the same cycle: the result is sticky=1 and count=1. The event is not lost.
- clear_i with no overflow: sticky=0, count=0.
- Lanes are fully independent except for the shared valid, shift, round and clear signals.

## Timing
- Latency is exactly 3 cycles from valid_i to valid_o.
- Throughput is one sample per cycle. There is no backpressure.
- Bubbles in valid_i propagate unchanged to valid_o.
- Reset values: valid_o=0, product_o=0, overflow_o=0, sticky_o=0, ovf_cnt_o=0. All pipeline valid bits are 0.
- Reset asserted mid-stream: samples in flight are discarded, and no valid_o pulse follows release for them.
- The first valid_o after release appears 3 cycles after the first valid_i that is sampled while rstn_i=1.
- sticky_o and ovf_cnt_o are registered. They reflect a saturated sample in the same cycle that its valid_o is high.

## Configuration
- PRODUCT_SAT_OVF_CNT_EN
  - Defined: per-lane CNT_BITS counters are built as described above.
  - Undefined: no counter registers are built, and ovf_cnt_o is tied to 0. sticky_o and overflow_o are unchanged.

## Structure
- Package red_pitaya_product_sat_pkg holds:
  - the round-mode constants (ROUND_TRUNC=0, ROUND_HALF_UP=1);
  - a clog2 function for SHIFT_W;
  - saturation-limit helper functions parameterised on width.
- Sub-module red_pitaya_product_sat_lane implements one lane's 3-stage datapath plus its sticky flag and counter.
- The top level generates CHANNELS instances of the lane. It also owns the valid, shift and round pipeline and the shift clamp.

## Test plan
- Reset: hold rstn_i low with random inputs → valid_o, product_o, overflow_o, sticky_o and ovf_cnt_o all 0.
- Rounding, shift=1, lane 0:
  - 7*1 with round_i=1 → 4; with round_i=0 → 3.
  - -7*1 with round_i=1 → -3; with round_i=0 → -4.
  - Each result appears exactly 3 cycles after valid_i.
- Saturation, lane 1, shift=0:
  - 8191*32767 → 8191, overflow_o=1.
  - -8192*32767 → -8192, overflow_o=1.
  - -8192*-32768 with shift=15 → 268435456>>>15 = 8192 → 8191, overflow=1.
  - Lane 0, driven in range, shows overflow_o=0.
- Sticky and counter:
  - Three overflowing samples → ovf_cnt_o=3, sticky=1.
  - clear_i in the same cycle as a 4th overflow → count=1, sticky=1.
  - With CNT_BITS=4, 20 overflows → count holds at 15.
- Streaming: valid_i pattern 1,1,0,1,0,0,1 → valid_o shows the same pattern delayed by 3. product_o holds its value during the gaps. shift_i changed between samples applies only to later samples.
- Reset mid-stream: drop rstn_i for 1 cycle with 2 samples in flight → no valid_o pulses for them. A new sample after release appears 3 cycles later.

Source files
------------

// File: rtl/red_pitaya_product_sat_pkg.sv
// Shared constants and helpers for the multi-channel saturating multiplier.
package red_pitaya_product_sat_pkg;

  localparam logic ROUND_TRUNC   = 1'b0;
  localparam logic ROUND_HALF_UP = 1'b1;

  // Bits needed to hold values 0..n-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (longint unsigned v = 1; v < longint'(n); v = v << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  function automatic int unsigned clamp_shift(input int unsigned s, input int unsigned m);
    return (s > m) ? m : s;
  endfunction

endpackage

// File: rtl/red_pitaya_product_sat_lane.sv
// One lane: multiply + round, arithmetic shift, saturate, plus sticky flag and overflow
// counter (counter present only with PRODUCT_SAT_OVF_CNT_EN).
module red_pitaya_product_sat_lane
  import red_pitaya_product_sat_pkg::*;
#(
  parameter int unsigned BITS_IN1  = 14,
  parameter int unsigned BITS_IN2  = 16,
  parameter int unsigned BITS_OUT  = 14,
  parameter int unsigned SHIFT_MAX = 31,
  parameter int unsigned CNT_BITS  = 16,
  parameter int unsigned SHIFT_W   = 5
) (
  input  logic                       clk,
  input  logic                       rstn_i,
  input  logic signed [BITS_IN1-1:0] factor1_i,
  input  logic signed [BITS_IN2-1:0] factor2_i,
  input  logic        [SHIFT_W-1:0]  shift_s0_i,
  input  logic                       round_s0_i,
  input  logic        [SHIFT_W-1:0]  shift_s1_i,
  input  logic                       valid_s2_i,
  input  logic                       clear_i,
  output logic signed [BITS_OUT-1:0] product_o,
  output logic                       overflow_o,
  output logic                       sticky_o,
  output logic        [CNT_BITS-1:0] ovf_cnt_o
);

  localparam int unsigned P = BITS_IN1 + BITS_IN2 + 1;
  // Wide enough that even the largest rounding constant cannot wrap the sum.
  localparam int unsigned W = (P > SHIFT_MAX + 1) ? P : SHIFT_MAX + 1;
  localparam longint OUT_MAX = sat_max(BITS_OUT);
  localparam longint OUT_MIN = sat_min(BITS_OUT);

  logic signed [W-1:0] op1, op2, round_add, p_d, p_q, s_d, s_q;
  logic signed [BITS_OUT-1:0] sat_d, product_q;
  logic ovf_d, overflow_q, sticky_q, hit;

  always_comb begin
    op1       = {{(W - BITS_IN1){factor1_i[BITS_IN1-1]}}, factor1_i};
    op2       = {{(W - BITS_IN2){factor2_i[BITS_IN2-1]}}, factor2_i};
    round_add = '0;
    if (round_s0_i == ROUND_HALF_UP && shift_s0_i != '0) begin
      round_add = {{(W - 1){1'b0}}, 1'b1} << (shift_s0_i - 1'b1);
    end
    p_d = op1 * op2 + round_add;
    s_d = p_q >>> shift_s1_i;
  end

  always_comb begin
    sat_d = s_q[BITS_OUT-1:0];
    ovf_d = 1'b0;
    if (longint'(s_q) > OUT_MAX) begin
      sat_d = BITS_OUT'(OUT_MAX);
      ovf_d = 1'b1;
    end else if (longint'(s_q) < OUT_MIN) begin
      sat_d = BITS_OUT'(OUT_MIN);
      ovf_d = 1'b1;
    end
  end

  assign hit = valid_s2_i & ovf_d;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      p_q        <= '0;
      s_q        <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      p_q        <= p_d;
      s_q        <= s_d;
      overflow_q <= hit;
      if (valid_s2_i) product_q <= sat_d;
      // A saturation coinciding with clear survives the clear.
      if (clear_i)  sticky_q <= hit;
      else if (hit) sticky_q <= 1'b1;
    end
  end

`ifdef PRODUCT_SAT_OVF_CNT_EN
  logic [CNT_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= hit ? CNT_BITS'(1) : '0;
    end else if (hit && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ovf_cnt_o = cnt_q;
`else
  assign ovf_cnt_o = '0;
`endif

  assign product_o  = product_q;
  assign overflow_o = overflow_q;
  assign sticky_o   = sticky_q;

endmodule

// File: rtl/red_pitaya_product_sat_mc.sv
// Multi-channel pipelined saturating multiplier, 3-cycle latency.
// Optional per-lane overflow counters are built when PRODUCT_SAT_OVF_CNT_EN is defined.
module red_pitaya_product_sat_mc
  import red_pitaya_product_sat_pkg::*;
#(
  parameter  int unsigned CHANNELS  = 2,
  parameter  int unsigned BITS_IN1  = 14,
  parameter  int unsigned BITS_IN2  = 16,
  parameter  int unsigned BITS_OUT  = 14,
  parameter  int unsigned SHIFT_MAX = 31,
  parameter  int unsigned CNT_BITS  = 16,
  localparam int unsigned SHIFT_W   = clog2(SHIFT_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         rstn_i,
  input  logic                         valid_i,
  input  logic [CHANNELS*BITS_IN1-1:0] factor1_i,
  input  logic [CHANNELS*BITS_IN2-1:0] factor2_i,
  input  logic [SHIFT_W-1:0]           shift_i,
  input  logic                         round_i,
  input  logic                         clear_i,
  output logic                         valid_o,
  output logic [CHANNELS*BITS_OUT-1:0] product_o,
  output logic [CHANNELS-1:0]          overflow_o,
  output logic [CHANNELS-1:0]          sticky_o,
  output logic [CHANNELS*CNT_BITS-1:0] ovf_cnt_o
);

  logic [SHIFT_W-1:0] shift_c, shift_s1_q;
  logic valid_s1_q, valid_s2_q, valid_s3_q;

  assign shift_c = SHIFT_W'(clamp_shift(32'(shift_i), SHIFT_MAX));

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_s1_q <= 1'b0;
      valid_s2_q <= 1'b0;
      valid_s3_q <= 1'b0;
      shift_s1_q <= '0;
    end else begin
      valid_s1_q <= valid_i;
      valid_s2_q <= valid_s1_q;
      valid_s3_q <= valid_s2_q;
      shift_s1_q <= shift_c;
    end
  end

  assign valid_o = valid_s3_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    red_pitaya_product_sat_lane #(
      .BITS_IN1  (BITS_IN1),
      .BITS_IN2  (BITS_IN2),
      .BITS_OUT  (BITS_OUT),
      .SHIFT_MAX (SHIFT_MAX),
      .CNT_BITS  (CNT_BITS),
      .SHIFT_W   (SHIFT_W)
    ) u_lane (
      .clk        (clk),
      .rstn_i     (rstn_i),
      .factor1_i  (factor1_i[k*BITS_IN1 +: BITS_IN1]),
      .factor2_i  (factor2_i[k*BITS_IN2 +: BITS_IN2]),
      .shift_s0_i (shift_c),
      .round_s0_i (round_i),
      .shift_s1_i (shift_s1_q),
      .valid_s2_i (valid_s2_q),
      .clear_i    (clear_i),
      .product_o  (product_o[k*BITS_OUT +: BITS_OUT]),
      .overflow_o (overflow_o[k]),
      .sticky_o   (sticky_o[k]),
      .ovf_cnt_o  (ovf_cnt_o[k*CNT_BITS +: CNT_BITS])
    );
  end

endmodule

// File: tb/tb_red_pitaya_product_sat_mc.sv
// Directed self-checking bench for red_pitaya_product_sat_mc (2 lanes, 4-bit counters).
module tb_red_pitaya_product_sat_mc;

`ifdef PRODUCT_SAT_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [27:0] factor1_i = '0;
  logic [31:0] factor2_i = '0;
  logic [4:0]  shift_i = '0;
  logic        round_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        valid_o;
  logic [27:0] product_o;
  logic [1:0]  overflow_o;
  logic [1:0]  sticky_o;
  logic [7:0]  ovf_cnt_o;

  int checks = 0;
  int errors = 0;

  red_pitaya_product_sat_mc #(
    .CHANNELS  (2),
    .BITS_IN1  (14),
    .BITS_IN2  (16),
    .BITS_OUT  (14),
    .SHIFT_MAX (31),
    .CNT_BITS  (4)
  ) dut (
    .clk        (clk),
    .rstn_i     (rstn_i),
    .valid_i    (valid_i),
    .factor1_i  (factor1_i),
    .factor2_i  (factor2_i),
    .shift_i    (shift_i),
    .round_i    (round_i),
    .clear_i    (clear_i),
    .valid_o    (valid_o),
    .product_o  (product_o),
    .overflow_o (overflow_o),
    .sticky_o   (sticky_o),
    .ovf_cnt_o  (ovf_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int a0, input int b0, input int a1, input int b1,
                         input int sh, input bit rnd);
    factor1_i = {14'(a1), 14'(a0)};
    factor2_i = {16'(b1), 16'(b0)};
    shift_i   = 5'(sh);
    round_i   = rnd;
  endtask

  task automatic launch(input int a0, input int b0, input int a1, input int b1,
                        input int sh, input bit rnd);
    set_ops(a0, b0, a1, b1, sh, rnd);
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_i   = 1'($urandom);
      factor1_i = 28'($urandom);
      factor2_i = $urandom;
      shift_i   = 5'($urandom);
      round_i   = 1'($urandom);
      clear_i   = 1'($urandom);
      step();
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", valid_o);
    end
    checks++;
    if (product_o !== '0) begin
      errors++; $display("FAIL reset_product: got %h expected 0", product_o);
    end
    checks++;
    if (overflow_o !== 2'b00 || sticky_o !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got ovf %b sticky %b expected 00 00",
                         overflow_o, sticky_o);
    end
    checks++;
    if (ovf_cnt_o !== 8'h00) begin
      errors++; $display("FAIL reset_cnt: got %h expected 00", ovf_cnt_o);
    end
    valid_i = 1'b0;
    clear_i = 1'b0;
    set_ops(0, 0, 0, 0, 0, 1'b0);
    rstn_i  = 1'b1;
    step();
  endtask

  task automatic test_rounding();
    int a[4]   = '{7, 7, -7, -7};
    bit rn[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    int exp[4] = '{4, 3, -3, -4};
    for (int i = 0; i < 4; i++) begin
      launch(a[i], 1, 0, 0, 1, rn[i]);
      step();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++; $display("FAIL round_early_%0d: valid_o got %b expected 0", i, valid_o);
      end
      step();
      checks++;
      if (valid_o !== 1'b1) begin
        errors++; $display("FAIL round_latency_%0d: valid_o got %b expected 1", i, valid_o);
      end
      checks++;
      if ($signed(product_o[13:0]) !== exp[i]) begin
        errors++; $display("FAIL round_value_%0d: got %0d expected %0d",
                           i, $signed(product_o[13:0]), exp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int a0[3] = '{8191, -8192, 8191};
    int b0[3] = '{1, 1, 32767};
    int a1[3] = '{8191, -8192, -8192};
    int b1[3] = '{32767, 32767, -32768};
    int sh[3] = '{0, 0, 15};
    int e0[3] = '{8191, -8192, 8190};
    int e1[3] = '{8191, -8192, 8191};
    for (int i = 0; i < 3; i++) begin
      launch(a0[i], b0[i], a1[i], b1[i], sh[i], 1'b0);
      step();
      checks++;
      if (overflow_o !== 2'b00) begin
        errors++; $display("FAIL sat_ovf_unqualified_%0d: got %b expected 00", i, overflow_o);
      end
      step();
      checks++;
      if (overflow_o !== 2'b10) begin
        errors++; $display("FAIL sat_ovf_%0d: got %b expected 10", i, overflow_o);
      end
      checks++;
      if ($signed(product_o[27:14]) !== e1[i] || $signed(product_o[13:0]) !== e0[i]) begin
        errors++; $display("FAIL sat_value_%0d: got %0d/%0d expected %0d/%0d", i,
                           $signed(product_o[27:14]), $signed(product_o[13:0]), e1[i], e0[i]);
      end
    end
  endtask

  task automatic test_sticky_count();
    logic [3:0] e;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++;
    if (sticky_o !== 2'b00 || ovf_cnt_o !== 8'h00) begin
      errors++; $display("FAIL clear_idle: got sticky %b cnt %h expected 00 00",
                         sticky_o, ovf_cnt_o);
    end
    set_ops(5, 5, 8191, 32767, 0, 1'b0);
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    valid_i = 1'b0;
    step();
    step();
    e = CNT_EN ? 4'd3 : 4'd0;
    checks++;
    if (ovf_cnt_o[7:4] !== e || ovf_cnt_o[3:0] !== 4'd0) begin
      errors++; $display("FAIL cnt_three: got %h expected %h0", ovf_cnt_o, e);
    end
    checks++;
    if (sticky_o !== 2'b10) begin
      errors++; $display("FAIL sticky_three: got %b expected 10", sticky_o);
    end
    launch(5, 5, 8191, 32767, 0, 1'b0);
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    e = CNT_EN ? 4'd1 : 4'd0;
    checks++;
    if (overflow_o !== 2'b10 || sticky_o !== 2'b10 || ovf_cnt_o[7:4] !== e) begin
      errors++; $display("FAIL clear_with_ovf: got ovf %b sticky %b cnt %h expected 10 10 %h",
                         overflow_o, sticky_o, ovf_cnt_o[7:4], e);
    end
    valid_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    valid_i = 1'b0;
    step();
    step();
    e = CNT_EN ? 4'd15 : 4'd0;
    checks++;
    if (ovf_cnt_o[7:4] !== e || sticky_o !== 2'b10) begin
      errors++; $display("FAIL cnt_saturate: got cnt %h sticky %b expected %h 10",
                         ovf_cnt_o[7:4], sticky_o, e);
    end
  endtask

  task automatic test_streaming();
    bit pat[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int a0[7]  = '{100, 100, 0, -50, 0, 0, 41};
    int b0[7]  = '{1, 1, 0, 3, 0, 0, 5};
    int a1[7]  = '{1, 2, 0, 4, 0, 0, 7};
    int sh[7]  = '{0, 2, 0, 1, 0, 0, 3};
    bit rn[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int e0[7]  = '{100, 25, 0, -75, 0, 0, 26};
    int e1[7]  = '{2, 1, 0, 4, 0, 0, 2};
    int cur0 = 0;
    int cur1 = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 7 && pat[i]) begin
        set_ops(a0[i], b0[i], a1[i], 2, sh[i], rn[i]);
        valid_i = 1'b1;
      end else begin
        // Out-of-range garbage with a different shift on idle cycles.
        set_ops(8191, 32767, -8192, 32767, 7, 1'b1);
        valid_i = 1'b0;
      end
      step();
      if (i >= 2) begin
        if (pat[i-2]) begin
          cur0 = e0[i-2];
          cur1 = e1[i-2];
        end
        checks++;
        if (valid_o !== pat[i-2]) begin
          errors++; $display("FAIL stream_valid_%0d: got %b expected %b", i, valid_o, pat[i-2]);
        end
        checks++;
        if ($signed(product_o[13:0]) !== cur0 || $signed(product_o[27:14]) !== cur1) begin
          errors++; $display("FAIL stream_product_%0d: got %0d/%0d expected %0d/%0d", i,
                             $signed(product_o[27:14]), $signed(product_o[13:0]), cur1, cur0);
        end
        checks++;
        if (overflow_o !== 2'b00) begin
          errors++; $display("FAIL stream_ovf_%0d: got %b expected 00", i, overflow_o);
        end
      end else begin
        checks++;
        if (valid_o !== 1'b0) begin
          errors++; $display("FAIL stream_valid_%0d: got %b expected 0", i, valid_o);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int pulses = 0;
    set_ops(3, 3, 1, 1, 0, 1'b0);
    valid_i = 1'b1;
    step();
    step();
    valid_i = 1'b0;
    rstn_i  = 1'b0;
    #1;
    checks++;
    if (product_o !== '0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL midreset_clear: got valid %b product %h expected 0 0",
                         valid_o, product_o);
    end
    step();
    rstn_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (valid_o) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL midreset_ghost: got %0d valid pulses expected 0", pulses);
    end
    launch(3, 3, -2, 5, 0, 1'b0);
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL midreset_early: got %b expected 0", valid_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b1 || $signed(product_o[13:0]) !== 9 ||
        $signed(product_o[27:14]) !== -10) begin
      errors++; $display("FAIL midreset_new: got valid %b %0d/%0d expected 1 -10/9", valid_o,
                         $signed(product_o[27:14]), $signed(product_o[13:0]));
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_sticky_count();
    test_streaming();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
